neopixel_rx: RTL and testbench

NEOPIXEL_RX -- requirements
Module: neopixel_rx

---
 rtl/neopixel_rx.sv | 194 +++++++++++++++++++
 tb/tb_neopixel_rx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_rx.sv
// WS2812 (NeoPixel) receiver: measures high/low pulse widths on the serial line,
// decodes GRB pixels into {R,G,B} words and flags frame boundaries on the latch gap.
module neopixel_rx #(
  parameter int C_PIXELS  = 12,
  parameter int C_FREQ_HZ = 125000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neopixel_in,
  input  logic        clear_status,
  output logic        pixel_valid,
  output logic [23:0] pixel_data,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_pixels,
  output logic [3:0]  status
);

  localparam longint unsigned C_REF_HZ = 64'd125000000;
  localparam logic [15:0] C_MIN_HIGH     = 16'((64'd12   * 64'(C_FREQ_HZ)) / C_REF_HZ);
  localparam logic [15:0] C_BIT_THRESH   = 16'((64'd75   * 64'(C_FREQ_HZ)) / C_REF_HZ);
  localparam logic [15:0] C_MAX_HIGH     = 16'((64'd250  * 64'(C_FREQ_HZ)) / C_REF_HZ);
  localparam logic [15:0] C_LATCH_CYCLES = 16'((64'd6250 * 64'(C_FREQ_HZ)) / C_REF_HZ);

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t      state, state_next;
  logic        sync_a, sync_b, line_d;
  logic        rise, fall;
  logic [15:0] high_cnt, low_cnt;
  logic [23:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [7:0]  pix_cnt;
  logic        word_done, bump;
  logic        load_high, inc_high, clr_low, inc_low;
  logic        shift_en, shift_val;
  logic        err_glitch, err_long, latch;
  logic        index_ok, overrun_set, partial_set;
  logic [3:0]  status_set;

  // Two flops resynchronise the pin, the third gives the previous level for edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      line_d <= 1'b0;
    end else begin
      sync_a <= neopixel_in;
      sync_b <= sync_a;
      line_d <= sync_b;
    end
  end

  assign rise = sync_b & ~line_d;
  assign fall = ~sync_b & line_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_high  = 1'b0;
    inc_high   = 1'b0;
    clr_low    = 1'b0;
    inc_low    = 1'b0;
    shift_en   = 1'b0;
    shift_val  = 1'b0;
    err_glitch = 1'b0;
    err_long   = 1'b0;
    latch      = 1'b0;
    case (state)
      ST_SYNC: begin
        if (sync_b) begin
          clr_low = 1'b1;
        end else begin
          inc_low = 1'b1;
          if (low_cnt >= C_LATCH_CYCLES - 16'd1) state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          load_high  = 1'b1;
          state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // high_cnt equals the number of cycles the pin was high when the fall arrives
        if (fall) begin
          clr_low = 1'b1;
          if (high_cnt < C_MIN_HIGH) begin
            err_glitch = 1'b1;
            state_next = ST_SYNC;
          end else begin
            shift_en   = 1'b1;
            shift_val  = (high_cnt >= C_BIT_THRESH);
            state_next = ST_LOW;
          end
        end else if (high_cnt >= C_MAX_HIGH) begin
          err_long   = 1'b1;
          clr_low    = 1'b1;
          state_next = ST_SYNC;
        end else begin
          inc_high = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          load_high  = 1'b1;
          state_next = ST_HIGH;
        end else begin
          inc_low = 1'b1;
          if (low_cnt >= C_LATCH_CYCLES - 16'd1) begin
            latch      = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_SYNC;
    endcase
  end

  assign index_ok    = 32'(pixel_index) < 32'(C_PIXELS);
  assign overrun_set = word_done & ~index_ok;
  assign partial_set = latch & (bit_cnt != 5'd0);
  assign status_set  = {overrun_set, partial_set, err_long, err_glitch};

  // Datapath: pulse counters, bit assembly, pixel/frame reporting and sticky status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      high_cnt     <= 16'd0;
      low_cnt      <= 16'd0;
      shift_reg    <= 24'd0;
      bit_cnt      <= 5'd0;
      pix_cnt      <= 8'd0;
      word_done    <= 1'b0;
      bump         <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_data   <= 24'd0;
      pixel_index  <= 8'd0;
      frame_done   <= 1'b0;
      frame_pixels <= 8'd0;
      status       <= 4'd0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      word_done   <= 1'b0;
      bump        <= 1'b0;

      if (load_high)     high_cnt <= 16'd1;
      else if (inc_high) high_cnt <= high_cnt + 16'd1;

      if (clr_low)                         low_cnt <= 16'd0;
      else if (inc_low && low_cnt != '1)   low_cnt <= low_cnt + 16'd1;

      if (shift_en) begin
        shift_reg <= {shift_reg[22:0], shift_val};
        if (bit_cnt == 5'd23) begin
          bit_cnt   <= 5'd0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      // The wire carries G,R,B; reorder into R,G,B for the output word.
      if (word_done) begin
        bump <= 1'b1;
        if (pix_cnt != 8'hFF) pix_cnt <= pix_cnt + 8'd1;
        if (index_ok) begin
          pixel_valid <= 1'b1;
          pixel_data  <= {shift_reg[15:8], shift_reg[23:16], shift_reg[7:0]};
        end
      end

      if (bump && pixel_index != 8'hFF) pixel_index <= pixel_index + 8'd1;

      if (latch) begin
        frame_done   <= 1'b1;
        frame_pixels <= pix_cnt;
      end

      if (latch || err_glitch || err_long) begin
        pixel_index <= 8'd0;
        bit_cnt     <= 5'd0;
        pix_cnt     <= 8'd0;
      end

      status <= (clear_status ? 4'd0 : status) | status_set;
    end
  end

endmodule

// File: tb/tb_neopixel_rx.sv
// Self-checking bench for neopixel_rx: random WS2812 streams at 25 MHz checked
// against a frame-level model of which pixels, indices and frame counts must appear.
module tb_neopixel_rx;

  localparam int PIXELS = 12;
  // At 25 MHz every 125 MHz cycle count is divided by five.
  localparam int MIN_H  = 2;
  localparam int THRESH = 15;
  localparam int MAX_H  = 50;
  localparam int GAP    = 1500;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        np_line = 1'b0;
  logic        clear_status = 1'b0;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic [3:0]  status;

  neopixel_rx #(.C_PIXELS(PIXELS), .C_FREQ_HZ(25000000)) dut (
    .clock(clock), .reset(reset), .neopixel_in(np_line), .clear_status(clear_status),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels), .status(status)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] data;
    logic [7:0]  index;
    longint      cyc;
  } pix_t;

  pix_t       got_pix[$];
  pix_t       exp_pix[$];
  logic [7:0] got_fp[$];
  longint     cyc = 0;
  int         overlap = 0;
  int         exp_idx = 0;
  int         checks = 0;
  int         failures = 0;
  bit         fixed_timing = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every reported pixel and frame boundary, sampled on the falling edge.
  always @(negedge clock) begin
    pix_t p;
    if (pixel_valid) begin
      p.data  = pixel_data;
      p.index = pixel_index;
      p.cyc   = cyc;
      got_pix.push_back(p);
    end
    if (frame_done) got_fp.push_back(frame_pixels);
    if (pixel_valid && frame_done) overlap = overlap + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit_h(input int h, input int l, output longint f);
    np_line = 1'b1;
    tick(h);
    np_line = 1'b0;
    f = cyc;
    tick(l);
  endtask

  task automatic send_bit(input logic b, output longint f);
    int h, l;
    if (fixed_timing) begin
      h = b ? 20 : 10;
      l = b ? 11 : 22;
    end else begin
      h = b ? int'($urandom_range(MAX_H, THRESH)) : int'($urandom_range(THRESH - 1, MIN_H));
      l = int'($urandom_range(20, 2));
    end
    send_bit_h(h, l, f);
  endtask

  task automatic send_random_bits(input int n);
    longint f;
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), f);
  endtask

  // Model: pixels arrive in wire order; only the first PIXELS of a frame are
  // reported, at their frame position, four cycles after their last falling edge.
  task automatic send_pixel(input logic [23:0] rgb);
    logic [23:0] wire_word;
    longint      f;
    pix_t        p;
    wire_word = {rgb[15:8], rgb[23:16], rgb[7:0]};
    for (int i = 23; i >= 0; i--) send_bit(wire_word[i], f);
    if (exp_idx < PIXELS) begin
      p.data  = rgb;
      p.index = 8'(exp_idx);
      p.cyc   = f + 4;
      exp_pix.push_back(p);
    end
    exp_idx++;
  endtask

  task automatic gap();
    np_line = 1'b0;
    tick(GAP);
    exp_idx = 0;
  endtask

  task automatic start_scn();
    got_pix.delete();
    exp_pix.delete();
    got_fp.delete();
    exp_idx = 0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    start_scn();
    reset = 1'b0;
    tick(4);
    checks++;
    if ({pixel_valid, frame_done, pixel_data, pixel_index, frame_pixels, status} !== 62'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {pixel_valid, frame_done, pixel_data, pixel_index, frame_pixels, status});
    end
    reset = 1'b1;
    tick(3);
    send_random_bits(24);
    gap();
    checks++;
    if (got_pix.size() !== 0 || got_fp.size() !== 0) begin
      failures++;
      $display("FAIL reset_no_report got=%0d/%0d exp=0/0", got_pix.size(), got_fp.size());
    end
  endtask

  task automatic test_single_pixel();
    start_scn();
    fixed_timing = 1'b1;
    send_pixel(24'h80FF00);
    gap();
    fixed_timing = 1'b0;
    checks++;
    if (got_pix.size() !== 1) begin
      failures++;
      $display("FAIL single_count got=%0d exp=1", got_pix.size());
    end else if (got_pix[0].data !== 24'h80FF00 || got_pix[0].index !== 8'd0 ||
                 got_pix[0].cyc !== exp_pix[0].cyc) begin
      failures++;
      $display("FAIL single_pixel got=%h/%0d@%0d exp=80ff00/0@%0d",
               got_pix[0].data, got_pix[0].index, got_pix[0].cyc, exp_pix[0].cyc);
    end
    checks++;
    if (got_fp.size() !== 1 || got_fp[0] !== 8'd1 || status !== 4'd0) begin
      failures++;
      $display("FAIL single_frame got=%0d frames status=%b exp=1 frame of 1, status 0000",
               got_fp.size(), status);
    end
  endtask

  task automatic test_full_frame();
    start_scn();
    for (int i = 1; i <= 12; i++) send_pixel(24'(i));
    gap();
    checks++;
    if (got_pix.size() !== exp_pix.size()) begin
      failures++;
      $display("FAIL full_count got=%0d exp=%0d", got_pix.size(), exp_pix.size());
    end
    foreach (exp_pix[k]) if (k < got_pix.size()) begin
      checks++;
      if (got_pix[k].data !== exp_pix[k].data || got_pix[k].index !== exp_pix[k].index ||
          got_pix[k].cyc !== exp_pix[k].cyc) begin
        failures++;
        $display("FAIL full_pixel%0d got=%h/%0d@%0d exp=%h/%0d@%0d", k, got_pix[k].data,
                 got_pix[k].index, got_pix[k].cyc, exp_pix[k].data, exp_pix[k].index, exp_pix[k].cyc);
      end
    end
    checks++;
    if (got_fp.size() !== 1 || got_fp[0] !== 8'd12 || status !== 4'd0) begin
      failures++;
      $display("FAIL full_frame got=%0d frames status=%b exp=1 frame of 12, status 0000",
               got_fp.size(), status);
    end
  endtask

  task automatic test_random_frames();
    for (int fr = 0; fr < 2; fr++) begin
      int n;
      start_scn();
      n = int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) send_pixel(24'($urandom));
      gap();
      checks++;
      if (got_pix.size() !== exp_pix.size()) begin
        failures++;
        $display("FAIL random_count got=%0d exp=%0d", got_pix.size(), exp_pix.size());
      end
      foreach (exp_pix[k]) if (k < got_pix.size()) begin
        checks++;
        if (got_pix[k].data !== exp_pix[k].data || got_pix[k].index !== exp_pix[k].index ||
            got_pix[k].cyc !== exp_pix[k].cyc) begin
          failures++;
          $display("FAIL random_pixel%0d got=%h/%0d@%0d exp=%h/%0d@%0d", k, got_pix[k].data,
                   got_pix[k].index, got_pix[k].cyc, exp_pix[k].data, exp_pix[k].index, exp_pix[k].cyc);
        end
      end
      checks++;
      if (got_fp.size() !== 1 || got_fp[0] !== 8'(n)) begin
        failures++;
        $display("FAIL random_frame got=%0d frames exp=1 frame of %0d", got_fp.size(), n);
      end
    end
  endtask

  // High widths sit exactly on the decode limits: 2 and 14 read as 0, 15 and 50 as 1.
  task automatic test_boundaries();
    int          widths[4];
    logic [23:0] wire_word;
    longint      f;
    widths = '{MIN_H, THRESH, THRESH - 1, MAX_H};
    start_scn();
    wire_word = 24'd0;
    for (int i = 0; i < 24; i++) begin
      send_bit_h(widths[i % 4], 9, f);
      wire_word = {wire_word[22:0], 1'(widths[i % 4] >= THRESH)};
    end
    gap();
    checks++;
    if (got_pix.size() !== 1 ||
        got_pix[0].data !== {wire_word[15:8], wire_word[23:16], wire_word[7:0]}) begin
      failures++;
      $display("FAIL boundary_pixel got=%0d pixels data=%h exp=1 pixel data=%h", got_pix.size(),
               (got_pix.size() > 0) ? got_pix[0].data : 24'd0,
               {wire_word[15:8], wire_word[23:16], wire_word[7:0]});
    end
    checks++;
    if (status !== 4'd0) begin
      failures++;
      $display("FAIL boundary_status got=%b exp=0000", status);
    end
  endtask

  task automatic test_overrun();
    start_scn();
    for (int i = 0; i < 13; i++) send_pixel(24'($urandom));
    gap();
    checks++;
    if (got_pix.size() !== 12) begin
      failures++;
      $display("FAIL overrun_count got=%0d exp=12", got_pix.size());
    end
    foreach (exp_pix[k]) if (k < got_pix.size()) begin
      checks++;
      if (got_pix[k].data !== exp_pix[k].data || got_pix[k].index !== exp_pix[k].index) begin
        failures++;
        $display("FAIL overrun_pixel%0d got=%h/%0d exp=%h/%0d", k, got_pix[k].data,
                 got_pix[k].index, exp_pix[k].data, exp_pix[k].index);
      end
    end
    checks++;
    if (got_fp.size() !== 1 || got_fp[0] !== 8'd13 || status !== 4'b1000) begin
      failures++;
      $display("FAIL overrun_frame got=%0d frames status=%b exp=1 frame of 13, status 1000",
               got_fp.size(), status);
    end
    pulse_clear();
    checks++;
    if (status !== 4'd0) begin
      failures++;
      $display("FAIL overrun_clear got=%b exp=0000", status);
    end
  endtask

  task automatic test_glitch();
    start_scn();
    send_random_bits(10);
    np_line = 1'b1;
    tick(1);
    np_line = 1'b0;
    tick(10);
    send_random_bits(38);
    gap();
    checks++;
    if (got_pix.size() !== 0 || got_fp.size() !== 0 || status !== 4'b0001) begin
      failures++;
      $display("FAIL glitch got=%0d pixels %0d frames status=%b exp=0 0 0001",
               got_pix.size(), got_fp.size(), status);
    end
    pulse_clear();
    start_scn();
    send_pixel(24'h123456);
    gap();
    checks++;
    if (got_pix.size() !== 1 || got_pix[0].data !== 24'h123456 || status !== 4'd0) begin
      failures++;
      $display("FAIL glitch_recover got=%0d pixels status=%b exp=1 pixel 123456 status 0000",
               got_pix.size(), status);
    end
  endtask

  task automatic test_long_high();
    start_scn();
    send_random_bits(5);
    np_line = 1'b1;
    tick(MAX_H + 1);
    np_line = 1'b0;
    tick(10);
    send_random_bits(19);
    gap();
    checks++;
    if (got_pix.size() !== 0 || got_fp.size() !== 0 || status !== 4'b0010) begin
      failures++;
      $display("FAIL long_high got=%0d pixels %0d frames status=%b exp=0 0 0010",
               got_pix.size(), got_fp.size(), status);
    end
    pulse_clear();
  endtask

  task automatic test_partial();
    start_scn();
    send_random_bits(10);
    gap();
    checks++;
    if (got_pix.size() !== 0 || got_fp.size() !== 1 || got_fp[0] !== 8'd0 || status !== 4'b0100) begin
      failures++;
      $display("FAIL partial got=%0d pixels %0d frames status=%b exp=0 pixels 1 frame of 0 status 0100",
               got_pix.size(), got_fp.size(), status);
    end
    pulse_clear();
    checks++;
    if (status !== 4'd0) begin
      failures++;
      $display("FAIL partial_clear got=%b exp=0000", status);
    end
  endtask

  task automatic test_midframe_reset();
    start_scn();
    send_random_bits(10);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_random_bits(1);
      checks++;
      if ({pixel_valid, frame_done, pixel_data, pixel_index, frame_pixels, status} !== 62'd0) begin
        failures++;
        $display("FAIL midreset_outputs got=%h exp=0",
                 {pixel_valid, frame_done, pixel_data, pixel_index, frame_pixels, status});
      end
    end
    reset = 1'b1;
    send_random_bits(35);
    gap();
    checks++;
    if (got_pix.size() !== 0 || got_fp.size() !== 0 || status !== 4'd0) begin
      failures++;
      $display("FAIL midreset_ignore got=%0d pixels %0d frames status=%b exp=0 0 0000",
               got_pix.size(), got_fp.size(), status);
    end
    start_scn();
    send_pixel(24'hA5C33C);
    gap();
    checks++;
    if (got_pix.size() !== 1 || got_pix[0].data !== 24'hA5C33C || got_pix[0].index !== 8'd0 ||
        got_fp.size() !== 1 || got_fp[0] !== 8'd1) begin
      failures++;
      $display("FAIL midreset_recover got=%0d pixels %0d frames exp=1 pixel a5c33c 1 frame of 1",
               got_pix.size(), got_fp.size());
    end
  endtask

  task automatic test_exclusive_strobes();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL strobe_overlap got=%0d exp=0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_random_frames();
    test_boundaries();
    test_overrun();
    test_glitch();
    test_long_high();
    test_partial();
    test_midframe_reset();
    test_exclusive_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
